// File: rtl/util_spi_pkg.sv
// Shared constants for the SPI responder: FSM encoding and clock-edge selection.
package util_spi_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    // The leading edge leaves CPOL. It is a rising edge when CPOL=0.
    // Sampling uses the leading edge when CPHA=0, so sampling happens on
    // a rising edge exactly when CPOL and CPHA are equal.
    function automatic bit sample_on_rise(input bit cpol, input bit cpha);
        return cpol == cpha;
    endfunction

endpackage

// File: rtl/util_sync_edge.sv
// Multi-flop synchronizer with one history flop. Produces the synchronized
// level plus single-cycle rise and fall pulses in the clk domain.
module util_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter bit RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Synchronizer chain and edge-history flop. Resetting both to the same
    // value means reset release can never produce an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/util_spi_slave.sv
// SPI responder endpoint. It oversamples scsn, sclk and mosi in the clk
// domain. Received words leave as a valid pulse stream. Transmit words are
// taken through a valid/ready handshake at the start of each word.
import util_spi_pkg::*;

module util_spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scsn,
    input  logic                  sclk,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_t,
    input  logic [DATA_WIDTH-1:0] s_tx_data,
    input  logic                  s_tx_valid,
    output logic                  s_tx_ready,
    output logic [DATA_WIDTH-1:0] m_rx_data,
    output logic                  m_rx_valid,
    output logic                  tx_underrun,
    output logic                  busy
);

    localparam bit SAMPLE_RISE = sample_on_rise(CPOL, CPHA);
    localparam int CNT_W       = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_WIDTH);

    logic scsn_level, scsn_rise, scsn_fall;
    logic sclk_level, sclk_rise, sclk_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic unused_sync;

    logic [1:0]            state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] tx_sr, rx_sr, rx_next, tx_adv;
    logic                  armed;
    logic                  sample_edge, shift_edge;

    // scsn resets to asserted, so a master already holding it low at reset
    // release is not treated as a new transaction.
    util_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_scsn (
        .clk(clk), .rst(rst), .din(scsn),
        .level(scsn_level), .rise(scsn_rise), .fall(scsn_fall)
    );

    util_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(sclk),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    util_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .din(mosi),
        .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign unused_sync = sclk_level ^ mosi_rise ^ mosi_fall;

    assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
    assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;

    // Next rx word and advanced tx word for the configured bit order.
    always_comb begin
        rx_next = MSB_FIRST ? {rx_sr[DATA_WIDTH-2:0], mosi_level}
                            : {mosi_level, rx_sr[DATA_WIDTH-1:1]};
        tx_adv  = MSB_FIRST ? {tx_sr[DATA_WIDTH-2:0], 1'b0}
                            : {1'b0, tx_sr[DATA_WIDTH-1:1]};
    end

    assign miso   = busy ? (MSB_FIRST ? tx_sr[DATA_WIDTH-1] : tx_sr[0]) : 1'b0;
    assign miso_t = ~busy;

    // Transaction FSM together with the rx and tx shift paths.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            armed       <= 1'b0;
            busy        <= 1'b0;
            s_tx_ready  <= 1'b0;
            tx_underrun <= 1'b0;
            m_rx_data   <= '0;
            m_rx_valid  <= 1'b0;
        end else begin
            s_tx_ready  <= 1'b0;
            tx_underrun <= 1'b0;
            m_rx_valid  <= 1'b0;
            if (scsn_level)
                armed <= 1'b1;

            // A sample edge completes its word even when scsn rises in the
            // same cycle.
            if (state == ST_ACTIVE && sample_edge && bit_cnt < FULL_CNT) begin
                rx_sr   <= rx_next;
                bit_cnt <= bit_cnt + CNT_W'(1);
                if (bit_cnt == LAST_BIT) begin
                    m_rx_data  <= rx_next;
                    m_rx_valid <= 1'b1;
                end
            end

            // A shift edge that arrives before the first sample of a word
            // does not advance the tx register. Under CPHA=0 this edge is the
            // trailing edge of the previous word. Under CPHA=1 it is the
            // first leading edge. In both cases the bit loaded by LOAD must
            // stay on miso.
            if (state == ST_ACTIVE && shift_edge && bit_cnt != '0)
                tx_sr <= tx_adv;

            if (scsn_rise) begin
                state   <= ST_IDLE;
                busy    <= 1'b0;
                bit_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (scsn_fall && armed)
                            state <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        if (s_tx_valid) begin
                            tx_sr      <= s_tx_data;
                            s_tx_ready <= 1'b1;
                        end else begin
                            tx_sr       <= '0;
                            tx_underrun <= 1'b1;
                        end
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= ST_ACTIVE;
                    end
                    ST_ACTIVE: begin
                        if (bit_cnt == FULL_CNT)
                            state <= ST_LOAD;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_util_spi_slave.sv
// Bench for util_spi_slave. There are three instances: mode 0 8-bit,
// mode 3 8-bit, and mode 0 16-bit LSB-first. A bit-banged master drives
// them. A scoreboard queue holds the expected rx words, and a feeder queue
// supplies tx words on s_tx_ready.
module tb_util_spi_slave;

    localparam int HALF = 8;   // clk cycles per sclk phase
    localparam int GAP  = 12;

    logic clk = 1'b0;
    logic rst;
    logic [2:0] scsn, sclk, mosi, miso, misot, rdy, rxv, und, busy, txv;
    logic [7:0]  tx_d0, tx_d1, rx0, rx1;
    logic [15:0] tx_d2, rx2;

    always #5 clk = ~clk;

    util_spi_slave #(.DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .rst(rst), .scsn(scsn[0]), .sclk(sclk[0]), .mosi(mosi[0]),
        .miso(miso[0]), .miso_t(misot[0]), .s_tx_data(tx_d0), .s_tx_valid(txv[0]),
        .s_tx_ready(rdy[0]), .m_rx_data(rx0), .m_rx_valid(rxv[0]),
        .tx_underrun(und[0]), .busy(busy[0]));

    util_spi_slave #(.DATA_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .rst(rst), .scsn(scsn[1]), .sclk(sclk[1]), .mosi(mosi[1]),
        .miso(miso[1]), .miso_t(misot[1]), .s_tx_data(tx_d1), .s_tx_valid(txv[1]),
        .s_tx_ready(rdy[1]), .m_rx_data(rx1), .m_rx_valid(rxv[1]),
        .tx_underrun(und[1]), .busy(busy[1]));

    util_spi_slave #(.DATA_WIDTH(16), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) dut2 (
        .clk(clk), .rst(rst), .scsn(scsn[2]), .sclk(sclk[2]), .mosi(mosi[2]),
        .miso(miso[2]), .miso_t(misot[2]), .s_tx_data(tx_d2), .s_tx_valid(txv[2]),
        .s_tx_ready(rdy[2]), .m_rx_data(rx2), .m_rx_valid(rxv[2]),
        .tx_underrun(und[2]), .busy(busy[2]));

    int tests = 0;
    int fails = 0;
    int rdy_cnt[3];
    int und_cnt[3];

    typedef struct packed { logic [1:0] sel; logic [15:0] data; } rx_exp_t;
    rx_exp_t     rxq[$];
    logic [15:0] txq0[$], txq1[$], txq2[$];

    typedef struct {
        int          sel;
        logic [15:0] tx;
        bit          tx_valid;
        logic [15:0] mw;
        logic [15:0] exp_miso;
        int          exp_rdy;
        int          exp_und;
    } vec_t;
    vec_t vecs[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int wbits(input int sel);
        return (sel == 2) ? 16 : 8;
    endfunction

    function automatic logic [15:0] rxdata(input int sel);
        case (sel)
            0: return {8'h00, rx0};
            1: return {8'h00, rx1};
            default: return rx2;
        endcase
    endfunction

    task automatic push_tx(input int sel, input logic [15:0] d);
        case (sel)
            0: txq0.push_back(d);
            1: txq1.push_back(d);
            default: txq2.push_back(d);
        endcase
    endtask

    task automatic push_rx(input int sel, input logic [15:0] d);
        rx_exp_t e;
        e.sel  = 2'(sel);
        e.data = d;
        rxq.push_back(e);
    endtask

    task automatic rx_seen(input int sel, input logic [15:0] d);
        rx_exp_t e;
        if (rxq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rx_unexpected: dut%0d produced %h with nothing expected", sel, d);
        end else begin
            e = rxq.pop_front();
            check("rx_sel", sel, 32'(e.sel));
            check("rx_data", {16'h0, d}, {16'h0, e.data});
        end
    endtask

    // Scoreboard consumer and pulse counters.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rxv[i]) rx_seen(i, rxdata(i));
            if (rdy[i]) rdy_cnt[i]++;
            if (und[i]) und_cnt[i]++;
        end
    end

    // The tx feeder pops the accepted word and presents the next one.
    always @(negedge clk) begin
        if (rdy[0] && txq0.size() > 0) void'(txq0.pop_front());
        if (rdy[1] && txq1.size() > 0) void'(txq1.pop_front());
        if (rdy[2] && txq2.size() > 0) void'(txq2.pop_front());
        txv[0] = txq0.size() > 0;
        txv[1] = txq1.size() > 0;
        txv[2] = txq2.size() > 0;
        tx_d0  = (txq0.size() > 0) ? txq0[0][7:0] : 8'h00;
        tx_d1  = (txq1.size() > 0) ? txq1[0][7:0] : 8'h00;
        tx_d2  = (txq2.size() > 0) ? txq2[0] : 16'h0000;
    end

    // Bit-banged master. It clocks bits first..first+n-1 and captures miso
    // on its own sample edge.
    task automatic spi_bits(input int sel, input logic [15:0] mw, input int first,
                            input int n, output logic [15:0] got);
        int w;
        bit cpol, cpha, msb;
        int idx;
        w    = wbits(sel);
        cpol = (sel == 1);
        cpha = (sel == 1);
        msb  = (sel != 2);
        got  = '0;
        for (int i = first; i < first + n; i++) begin
            idx = msb ? (w - 1 - i) : i;
            if (!cpha) begin
                mosi[sel] = mw[idx];
                wait_clk(HALF);
                got[idx]  = miso[sel];
                sclk[sel] = ~cpol;
                wait_clk(HALF);
                sclk[sel] = cpol;
            end else begin
                sclk[sel] = ~cpol;
                mosi[sel] = mw[idx];
                wait_clk(HALF);
                got[idx]  = miso[sel];
                sclk[sel] = cpol;
                wait_clk(HALF);
            end
        end
    endtask

    task automatic run_xfer(input int sel, input logic [15:0] mw, output logic [15:0] got);
        scsn[sel] = 1'b0;
        wait_clk(HALF);
        check("busy_active", 32'(busy[sel]), 32'd1);
        check("misot_active", 32'(misot[sel]), 32'd0);
        spi_bits(sel, mw, 0, wbits(sel), got);
        wait_clk(HALF);
        scsn[sel] = 1'b1;
        wait_clk(GAP);
        check("busy_idle", 32'(busy[sel]), 32'd0);
        check("misot_idle", 32'(misot[sel]), 32'd1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] got, got2;
        int r0, u0, seen;

        // A finished word always re-enters LOAD while scsn is still low. That
        // LOAD either accepts the next queued word or reports an underrun,
        // and is then abandoned when scsn rises.
        vecs[0] = '{sel: 0, tx: 16'h003C, tx_valid: 1'b1, mw: 16'h00A5, exp_miso: 16'h003C, exp_rdy: 1, exp_und: 1};
        vecs[1] = '{sel: 0, tx: 16'h0000, tx_valid: 1'b0, mw: 16'h0081, exp_miso: 16'h0000, exp_rdy: 0, exp_und: 2};
        vecs[2] = '{sel: 2, tx: 16'hB4C1, tx_valid: 1'b1, mw: 16'h0001, exp_miso: 16'hB4C1, exp_rdy: 1, exp_und: 1};

        rst  = 1'b1;
        scsn = 3'b111;
        sclk = 3'b010;
        mosi = 3'b000;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(2);
        for (int s = 0; s < 3; s++) begin
            check("rst_miso", 32'(miso[s]), 32'd0);
            check("rst_misot", 32'(misot[s]), 32'd1);
            check("rst_busy", 32'(busy[s]), 32'd0);
            check("rst_rxdata", 32'(rxdata(s)), 32'd0);
        end
        wait_clk(GAP);

        for (int v = 0; v < 3; v++) begin
            if (vecs[v].tx_valid) push_tx(vecs[v].sel, vecs[v].tx);
            push_rx(vecs[v].sel, vecs[v].mw);
            r0 = rdy_cnt[vecs[v].sel];
            u0 = und_cnt[vecs[v].sel];
            wait_clk(2);
            run_xfer(vecs[v].sel, vecs[v].mw, got);
            check("vec_miso", 32'(got), 32'(vecs[v].exp_miso));
            check("vec_rdy", rdy_cnt[vecs[v].sel] - r0, vecs[v].exp_rdy);
            check("vec_und", und_cnt[vecs[v].sel] - u0, vecs[v].exp_und);
            check("vec_rxhold", 32'(rxdata(vecs[v].sel)), 32'(vecs[v].mw));
            check("vec_drained", rxq.size(), 0);
            if (vecs[v].sel == 2) check("lsb_first_bit", 32'(got[0]), 32'(vecs[v].tx[0]));
        end

        // Mode 3, two back-to-back words in one chip-select window.
        push_tx(1, 16'h00F0);
        push_tx(1, 16'h000F);
        push_rx(1, 16'h0012);
        push_rx(1, 16'h0034);
        r0 = rdy_cnt[1];
        u0 = und_cnt[1];
        wait_clk(2);
        scsn[1] = 1'b0;
        wait_clk(HALF);
        spi_bits(1, 16'h0012, 0, 8, got);
        spi_bits(1, 16'h0034, 0, 8, got2);
        wait_clk(HALF);
        scsn[1] = 1'b1;
        wait_clk(GAP);
        check("m3_miso0", 32'(got), 32'h00F0);
        check("m3_miso1", 32'(got2), 32'h000F);
        check("m3_rdy", rdy_cnt[1] - r0, 2);
        check("m3_und", und_cnt[1] - u0, 1);
        check("m3_drained", rxq.size(), 0);

        // Abort after 5 bits. The word accepted at LOAD is dropped and not
        // replayed.
        push_tx(0, 16'h0077);
        r0 = rdy_cnt[0];
        wait_clk(2);
        scsn[0] = 1'b0;
        wait_clk(HALF);
        spi_bits(0, 16'h00FF, 0, 5, got);
        scsn[0] = 1'b1;
        seen = 0;
        for (int c = 0; c < 4 && seen == 0; c++) begin
            wait_clk(1);
            if (misot[0]) seen = 1;
        end
        check("abort_misot", seen, 1);
        check("abort_rdy", rdy_cnt[0] - r0, 1);
        wait_clk(GAP);
        push_tx(0, 16'h00C6);
        push_rx(0, 16'h005A);
        wait_clk(2);
        run_xfer(0, 16'h005A, got);
        check("abort_next_miso", 32'(got), 32'h00C6);
        check("abort_drained", rxq.size(), 0);

        // Reset at bit 3 while scsn is low.
        push_tx(0, 16'h0011);
        wait_clk(2);
        scsn[0] = 1'b0;
        wait_clk(HALF);
        spi_bits(0, 16'h00FF, 0, 3, got);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(1);
        check("midrst_busy", 32'(busy[0]), 32'd0);
        check("midrst_misot", 32'(misot[0]), 32'd1);
        check("midrst_miso", 32'(miso[0]), 32'd0);
        check("midrst_rxdata", 32'(rx0), 32'd0);
        spi_bits(0, 16'h00FF, 3, 5, got);
        wait_clk(HALF);
        check("midrst_ignored_busy", 32'(busy[0]), 32'd0);
        scsn[0] = 1'b1;
        wait_clk(GAP);
        push_tx(0, 16'h003C);
        push_rx(0, 16'h00C3);
        wait_clk(2);
        run_xfer(0, 16'h00C3, got);
        check("midrst_next_miso", 32'(got), 32'h003C);
        check("midrst_drained", rxq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/util_spi_slave.md
Name: util_spi_slave

Overview:
- SPI responder (slave) endpoint; the peripheral-side counterpart of the master SPI pin adapter.
- Takes raw scsn/sclk/mosi pins from an external or on-chip SPI master, oversamples them in the system clock domain, and shifts words in and out.
- Exposes received words as a valid-pulse stream and takes transmit words through a valid/ready handshake.
- Used to emulate SPI peripherals and for loopback verification of master-side logic.

Parameters:
- DATA_WIDTH, 8, bits per SPI word (4..32).
- CPOL, 1'b0, sclk idle level.
- CPHA, 1'b0, 0 = sample on leading edge, 1 = sample on trailing edge.
- MSB_FIRST, 1, 1 = MSB shifted first, 0 = LSB first.
- SYNC_STAGES, 2, synchronizer depth for scsn/sclk/mosi (2..4).

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- scsn  input  1  chip select, active low, asynchronous to clk.
- sclk  input  1  SPI clock, asynchronous to clk.
- mosi  input  1  master-out data.
- miso  output  1  slave-out data.
- miso_t  output  1  miso tristate enable, 1 = high-Z.
- s_tx_data  input  DATA_WIDTH  next word to transmit.
- s_tx_valid  input  1  s_tx_data valid.
- s_tx_ready  output  1  one-cycle accept pulse.
- m_rx_data  output  DATA_WIDTH  last complete received word.
- m_rx_valid  output  1  one-cycle pulse; no backpressure.
- tx_underrun  output  1  one-cycle pulse: word load with s_tx_valid=0.
- busy  output  1  1 while a transaction is active.

Behaviour:
- Reset values: miso=0, miso_t=1, s_tx_ready=0, m_rx_data=0, m_rx_valid=0, tx_underrun=0, busy=0, state=IDLE, bit counter=0.
- scsn, sclk, mosi each pass through SYNC_STAGES flops plus one edge-history flop.
- Synchronizer and history flops for scsn reset to 0 (asserted), so no spurious falling edge at reset release.
- The FSM is armed only after a synchronized scsn=1 has been seen.
- Leading edge = sclk leaving CPOL; trailing edge = sclk returning to CPOL.
- Sample edge = leading if CPHA=0, trailing if CPHA=1; the shift edge is the opposite edge.
- Legal input timing: sclk high and low phases each >= SYNC_STAGES+3 clk cycles. Setup from scsn fall to first sclk edge >= SYNC_STAGES+3 clk cycles.
- FSM states: IDLE, LOAD, ACTIVE.
  - IDLE -> LOAD on armed, synchronized scsn falling edge.
  - LOAD (1 cycle): if s_tx_valid, copy s_tx_data into tx shift register and pulse s_tx_ready; otherwise load all zeros and pulse tx_underrun. Clear bit counter, set busy=1, miso_t=0. Go to ACTIVE.
  - ACTIVE, sample edge: shift synchronized mosi into rx shift register and increment bit counter.
  - ACTIVE, shift edge: advance tx shift register, with the current bit driven on miso.
  - ACTIVE -> LOAD when the bit counter reaches DATA_WIDTH, i.e. on the cycle after the final sample edge.
  - Any state -> IDLE on synchronized scsn rising edge: busy=0, miso_t=1, miso=0, bit counter cleared.
- CPHA=0: the first tx bit is on miso at LOAD exit, before the first leading edge. The shift edge after the final sample edge of a word is ignored, because LOAD reloads.
- CPHA=1: miso holds the first bit from LOAD. The first leading edge (a shift edge) does not advance the register; each later leading edge advances one bit.
- Bit order: MSB_FIRST=1 sends and receives bit DATA_WIDTH-1 first; MSB_FIRST=0 sends and receives bit 0 first.
- Rx: on the final sample edge, m_rx_data takes the assembled word and m_rx_valid pulses on the next clk cycle. m_rx_data holds until the next complete word.
- Abort: scsn rises before DATA_WIDTH samples. The partial word is discarded with no m_rx_valid. A word already accepted by s_tx_ready is dropped, not replayed.
- Simultaneous scsn rise and final sample edge in the same cycle: the word completes (m_rx_valid pulses), then IDLE; no LOAD.
- Reset mid-transaction: all outputs return to reset values. The block waits for scsn high, then a new fall, before responding.

Decomposition:
- util_spi_pkg:
  - FSM state encoding localparams (IDLE/LOAD/ACTIVE).
  - Edge-select helper constants derived from CPOL/CPHA.
- Sub-module util_sync_edge (parameters SYNC_STAGES, RESET_VAL), instantiated for scsn, sclk and mosi.
  - Outputs: synchronized level, rise pulse, fall pulse.

Test Plan:
- Mode 0, 8 bits, s_tx_data=0x3C valid before scsn fall; master sends 0xA5 -> s_tx_ready one pulse; m_rx_data=0xA5 with one m_rx_valid pulse; miso bits 0,0,1,1,1,1,0,0.
- Mode 3 (CPOL=1, CPHA=1); two back-to-back words 0x12 then 0x34 with tx 0xF0, 0x0F queued -> two m_rx_valid pulses (0x12, 0x34); miso returns 0xF0, 0x0F; two s_tx_ready pulses.
- Underrun: s_tx_valid=0, master sends 0x81 -> tx_underrun pulse at LOAD; miso all 0; m_rx_data=0x81.
- Abort: scsn rises after 5 sclk cycles -> no m_rx_valid; miso_t=1 within SYNC_STAGES+2 cycles; the next full transfer 0x5A is received correctly.
- Reset while scsn low at bit 3 -> outputs at reset values. Remaining edges ignored with no m_rx_valid. After scsn high then low, 0xC3 is received.
- MSB_FIRST=0, DATA_WIDTH=16, master sends 0x0001 LSB-first -> m_rx_data=0x0001; first miso bit = s_tx_data[0].
